// File: rtl/sc_pkt_fifo_infill.sv
// sc_pkt_fifo_infill: single-clock Avalon-ST packet FIFO, show-ahead, with CSR fill-level readback.
// Ports: clk/reset_n (async active-low); csr_* (addr 0 reads count, registered, 1-cycle lag);
//        in_* Avalon-ST sink (in_ready = count < FIFO_DEPTH); out_* Avalon-ST source, 1-cycle write-to-read latency.
module sc_pkt_fifo_infill #(
  parameter int SYMBOLS_PER_BEAT = 64,
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int FIFO_DEPTH       = 512,
  parameter int USE_PACKETS      = 1,
  localparam int DW = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [2:0]    csr_address,
  input  logic          csr_read,
  input  logic          csr_write,
  input  logic [31:0]   csr_writedata,
  output logic [31:0]   csr_readdata,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_startofpacket,
  input  logic          in_endofpacket,
  input  logic [5:0]    in_empty,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_startofpacket,
  output logic          out_endofpacket,
  output logic [5:0]    out_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int W  = DW + 8;
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          ready_en;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          load;
  logic [W-1:0]  in_word;
  logic [W-1:0]  ram_q;
  logic [W-1:0]  byp_q;
  logic          sel_byp;
  logic [W-1:0]  head;

  // Sideband bits are forced to zero when packets are disabled, so the
  // stored word and therefore the out_ fields read back as 0.
  assign in_word = (USE_PACKETS != 0) ? {in_data, in_startofpacket, in_endofpacket, in_empty}
                                      : {in_data, 8'd0};

  // ready_en keeps in_ready low while reset is asserted and until the first edge after release.
  assign in_ready  = ready_en && (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign rd_nxt    = rd_ptr + {{(AW-1){1'b0}}, pop};

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;
  end

  // The incoming word becomes the head when nothing else will remain after
  // this edge (FIFO empty, or one word being popped). The RAM read would see
  // stale data at that address, so the word is captured in a bypass register.
  assign bypass = push && (count == {{AW{1'b0}}, pop});
  // A head word exists after this edge, so the output stage must be refreshed.
  assign load   = (count_nxt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      count    <= count_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_nxt;
    end
  end

  // Storage array: contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_word;
  end

  // Registered read port plus bypass register; both hold when the FIFO goes
  // empty so the out_ fields keep their last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_q   <= '0;
      byp_q   <= '0;
      sel_byp <= 1'b0;
    end else if (load) begin
      sel_byp <= bypass;
      if (bypass) byp_q <= in_word;
      else        ram_q <= mem[rd_nxt];
    end
  end

  assign head              = sel_byp ? byp_q : ram_q;
  assign out_data          = head[W-1:8];
  assign out_startofpacket = head[7];
  assign out_endofpacket   = head[6];
  assign out_empty         = head[5:0];

  // CSR: address 0 returns the fill level, all other addresses return 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csr_readdata <= '0;
    end else if (csr_read) begin
      csr_readdata <= (csr_address == 3'd0) ? 32'(count) : 32'd0;
    end
  end

  // Writes have no effect on this block.
  logic unused_csr;
  assign unused_csr = ^{csr_write, csr_writedata};

endmodule

// File: tb/tb_sc_pkt_fifo_infill.sv
module tb_sc_pkt_fifo_infill;
  localparam int DW    = 512;
  localparam int DEPTH = 512;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [5:0]    empty;
  } beat_t;

  logic          clk;
  logic          reset_n;
  logic [2:0]    csr_address;
  logic          csr_read;
  logic          csr_write;
  logic [31:0]   csr_writedata;
  logic [31:0]   csr_readdata;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          in_startofpacket;
  logic          in_endofpacket;
  logic [5:0]    in_empty;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_startofpacket;
  logic          out_endofpacket;
  logic [5:0]    out_empty;

  sc_pkt_fifo_infill dut (
    .clk(clk), .reset_n(reset_n),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket), .in_empty(in_empty),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket), .out_empty(out_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  beat_t       q[$];
  beat_t       last_pop;
  bit          have_last = 0;
  int          n_pop = 0;
  logic [31:0] exp_csr = '0;

  task automatic chk(input string name, input logic [DW+7:0] act, input logic [DW+7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // Monitor / scoreboard: at each falling edge the inputs for the next rising
  // edge are stable, so the model queue length equals the DUT fill level.
  always @(negedge clk) begin
    int    cnt;
    beat_t o;
    beat_t e;
    beat_t b;
    if (!reset_n) begin
      q.delete();
      have_last = 0;
      exp_csr   = '0;
    end else begin
      cnt = q.size();
      chk("out_valid", out_valid, cnt != 0);
      chk("in_ready", in_ready, cnt < DEPTH);
      chk("csr_readdata", csr_readdata, exp_csr);
      o = {out_data, out_startofpacket, out_endofpacket, out_empty};
      if (out_valid && out_ready) begin
        if (cnt == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got out_valid=1 expected empty model queue");
        end else begin
          e = q.pop_front();
          chk("out_beat", o, e);
          last_pop  = e;
          have_last = 1;
          n_pop++;
        end
      end else if (!out_valid && have_last) begin
        chk("out_hold", o, last_pop);
      end
      if (in_valid && in_ready) begin
        b = {in_data, in_startofpacket, in_endofpacket, in_empty};
        q.push_back(b);
      end
      if (csr_read) exp_csr = (csr_address == 3'd0) ? 32'(cnt) : 32'd0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    int k;
    k = 0;
    while ((q.size() != 0 || out_valid) && k < 5000) begin
      tick();
      k++;
    end
    chk(name, q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int    np0;
    int    idx;
    bit    acc;
    reset_n = 1'b0;
    csr_address = 3'd0; csr_read = 1'b1; csr_write = 1'b0; csr_writedata = '0;
    in_data = '0; in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0; in_empty = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1 reset_n = 1'b1;
    tick();

    // Reset then idle
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_csr", csr_readdata, 32'd0);
    csr_write = 1'b1; csr_writedata = 32'hFFFF_FFFF; csr_address = 3'd5;
    tick();
    csr_write = 1'b0; csr_address = 3'd0;
    tick();

    // Single beat
    in_data = {64{8'hA5}}; in_startofpacket = 1'b1; in_endofpacket = 1'b1; in_empty = 6'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_valid", out_valid, 1'b1);
    chk("single_data", out_data, {64{8'hA5}});
    chk("single_sop", out_startofpacket, 1'b1);
    chk("single_eop", out_endofpacket, 1'b1);
    chk("single_empty", out_empty, 6'd5);
    tick();
    chk("single_csr", csr_readdata, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_popped", out_valid, 1'b0);
    tick();
    chk("single_csr0", csr_readdata, 32'd0);

    // Fill to full, drop the extra write, then drain in order
    for (int i = 0; i < DEPTH; i++) begin
      in_data = DW'(i); in_startofpacket = (i == 0); in_endofpacket = (i == DEPTH-1);
      in_empty = 6'(i); in_valid = 1'b1;
      tick();
    end
    chk("full_in_ready", in_ready, 1'b0);
    in_data = DW'(999);
    tick();
    in_valid = 1'b0;
    chk("full_csr", csr_readdata, 32'(DEPTH));
    out_ready = 1'b1;
    wait_empty("fill_drain");
    out_ready = 1'b0;
    tick();

    // Streaming with both sides always ready
    np0 = n_pop;
    out_ready = 1'b1; in_valid = 1'b1; in_startofpacket = 1'b0; in_endofpacket = 1'b0; in_empty = '0;
    for (int i = 0; i < 2000; i++) begin
      in_data = DW'(i + 5000);
      tick();
      if (i == 1000) chk("stream_csr", csr_readdata, 32'd1);
    end
    in_valid = 1'b0;
    wait_empty("stream_drain");
    chk("stream_pops", n_pop - np0, 2000);
    out_ready = 1'b0;

    // Random backpressure over 10-beat packets
    idx = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_data = rand_data();
      in_startofpacket = (idx == 0);
      in_endofpacket = (idx == 9);
      in_empty = (idx == 9) ? 6'($urandom_range(0, 63)) : 6'd0;
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) idx = (idx + 1) % 10;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_empty("random_drain");
    out_ready = 1'b0;

    // Reset mid-operation
    for (int i = 0; i < 100; i++) begin
      in_data = rand_data(); in_startofpacket = (i % 10 == 0); in_endofpacket = (i % 10 == 9);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_csr", csr_readdata, 32'd0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_side", {out_startofpacket, out_endofpacket, out_empty}, 8'd0);
    @(negedge clk); #1 reset_n = 1'b1;
    tick();
    chk("rst_release_ready", in_ready, 1'b1);
    np0 = n_pop;
    in_data = DW'(32'h1234); in_startofpacket = 1'b1; in_endofpacket = 1'b1; in_empty = 6'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst_first_word", out_data, DW'(32'h1234));
    out_ready = 1'b1;
    wait_empty("rst_drain");
    chk("rst_pops", n_pop - np0, 1);
    out_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
